rom_sequencer: RTL and testbench
================================

# rom_sequencer

Fetch/execute controller for the program ROM: drives the ROM address, captures each operator/operand pair and executes it against a 32-bit accumulator. It sits between the combinational program ROM and downstream result logic, producing results over a valid/ready stream. A step watchdog traps runaway programs.

## Interface
- START_ADDR, 16'h0000, PC loaded on start
- MAX_STEPS, 32'd1000000, instructions allowed per run before the watchdog trap (must be ≥1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, no other reset
- start  in  1  run request, sampled only in IDLE/DONE/ERROR
- rom_addr  out  16  ROM address (= PC register)
- rom_operator  in  16  ROM operator word for rom_addr (combinational ROM)
- rom_operand  in  16  ROM operand word for rom_addr
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  32  result value (accumulator snapshot)
- acc  out  32  accumulator
- busy  out  1  high in FETCH/EXEC/OUT_WAIT
- done  out  1  program halted normally; sticky until next start
- error  out  1  illegal opcode or watchdog; sticky until next start
- step_count  out  32  instructions executed this run

## Operation
- States: IDLE, FETCH, EXEC, OUT_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + start=1 → FETCH; PC←START_ADDR, acc←0, step_count←0, done←0, error←0. Start is ignored while busy.
- FETCH: latch rom_operator/rom_operand into instruction registers → EXEC.
- EXEC: if step_count == MAX_STEPS → ERROR (instruction not executed). Otherwise step_count+1, then decode:
  - 0x0000 NOP: PC+1
  - 0x0001 LOAD: acc←zero-extended operand, PC+1
  - 0x0002 ADD: acc←acc+operand mod 2^32, PC+1
  - 0x0003 SUB: acc←acc−operand mod 2^32, PC+1
  - 0x0004 JMP: PC←operand
  - 0x0005 JZ: PC←operand if acc==0, else PC+1
  - 0x0006 OUT: out_data←acc → OUT_WAIT
  - 0x0007 HALT: → DONE, PC unchanged
  - any other value → ERROR, acc and PC unchanged (PC points at the faulting word)
- Non-OUT/HALT/illegal instructions return to FETCH.
- OUT_WAIT: out_valid=1, out_data stable; on an edge with out_ready=1 → PC+1, FETCH.
- PC+1 wraps 16'hFFFF → 16'h0000.
- DONE/ERROR hold all registers until start or reset.

## Timing
- Reset values: state IDLE, rom_addr=START_ADDR, acc=0, out_data=0, out_valid=0, busy=0, done=0, error=0, step_count=0.
- Reset is asynchronous: on assertion, out_valid drops and all outputs return to reset values immediately, even mid-run or mid-handshake. The first start is accepted on the first edge after deassertion.
- Start sampled at edge E: FETCH after E, busy=1 from E.
- Each instruction takes 2 cycles (FETCH at edge E+1, EXEC at edge E+2). OUT adds ≥1 cycle in OUT_WAIT.
- out_valid is asserted the cycle after EXEC of OUT. The transfer completes on the first edge with out_ready=1. If out_ready is already high, the stall is exactly 1 cycle.
- done/error are registered, high from the EXEC edge of HALT, illegal opcode or trap. busy falls on that same edge.
- rom_addr changes only on EXEC or OUT_WAIT completion edges, so ROM data is stable through FETCH.

## Test plan
- Program LOAD 5, ADD 3, OUT, HALT; out_ready=1; start at edge E → out_valid high after E+6 with out_data=8, transfer at E+7, done=1 after E+9, step_count=4, acc=8.
- Loop LOAD 3 / SUB 1 / JZ 4 / JMP 1 / HALT@4 → done=1, acc=0, step_count=10, rom_addr=4, no out_valid pulses.
- Backpressure: same as the first test with out_ready low for 5 cycles after out_valid → out_valid and out_data=8 held constant, PC holds at 2, done 5 cycles later than in the first test.
- Illegal opcode 0x00FF at address 1 after LOAD 7 → error=1, done=0, acc=7, rom_addr=1, busy=0. A later start clears error and reruns.
- Watchdog: MAX_STEPS=16, JMP 0 at address 0 → error=1 after edge E+34, step_count=16. Also SUB 1 from acc=0 gives acc=32'hFFFFFFFF. PC wrap: JMP 16'hFFFF onto a NOP fetches address 0 next.
- Assert reset in OUT_WAIT → out_valid=0 and busy=0 immediately, all outputs at reset values. A start after release runs the program from START_ADDR.

Source files
------------

// File: rtl/rom_sequencer.sv
// Fetch/execute controller: walks a combinational program ROM, runs each
// operator/operand pair against a 32-bit accumulator and streams OUT results.
module rom_sequencer #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [31:0] MAX_STEPS  = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_operator,
  input  logic [15:0] rom_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] acc,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] step_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    OUT_WAIT,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] OP_NOP  = 16'h0000;
  localparam logic [15:0] OP_LOAD = 16'h0001;
  localparam logic [15:0] OP_ADD  = 16'h0002;
  localparam logic [15:0] OP_SUB  = 16'h0003;
  localparam logic [15:0] OP_JMP  = 16'h0004;
  localparam logic [15:0] OP_JZ   = 16'h0005;
  localparam logic [15:0] OP_OUT  = 16'h0006;
  localparam logic [15:0] OP_HALT = 16'h0007;

  state_t      state;
  logic [15:0] instr_op;
  logic [15:0] instr_arg;
  logic [31:0] arg_ext;

  assign arg_ext = {16'h0000, instr_arg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rom_addr   <= START_ADDR;
      instr_op   <= 16'h0000;
      instr_arg  <= 16'h0000;
      acc        <= 32'd0;
      out_data   <= 32'd0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      step_count <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= FETCH;
            rom_addr   <= START_ADDR;
            acc        <= 32'd0;
            step_count <= 32'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
          end
        end

        FETCH: begin
          instr_op  <= rom_operator;
          instr_arg <= rom_operand;
          state     <= EXEC;
        end

        EXEC: begin
          // The watchdog traps before the instruction gets to run.
          if (step_count == MAX_STEPS) begin
            state <= ERROR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            step_count <= step_count + 32'd1;
            state      <= FETCH;
            case (instr_op)
              OP_NOP:  rom_addr <= rom_addr + 16'd1;
              OP_LOAD: begin
                acc      <= arg_ext;
                rom_addr <= rom_addr + 16'd1;
              end
              OP_ADD: begin
                acc      <= acc + arg_ext;
                rom_addr <= rom_addr + 16'd1;
              end
              OP_SUB: begin
                acc      <= acc - arg_ext;
                rom_addr <= rom_addr + 16'd1;
              end
              OP_JMP:  rom_addr <= instr_arg;
              OP_JZ:   rom_addr <= (acc == 32'd0) ? instr_arg : rom_addr + 16'd1;
              OP_OUT: begin
                out_data  <= acc;
                out_valid <= 1'b1;
                state     <= OUT_WAIT;
              end
              OP_HALT: begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
              default: begin
                state <= ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
              end
            endcase
          end
        end

        OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rom_addr  <= rom_addr + 16'd1;
            state     <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed timing scenarios plus random programs
// checked against a simple instruction-level interpreter.
module tb_rom_sequencer;

  localparam logic [31:0] MAXS = 32'd16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] rom_addr;
  logic [15:0] rom_operator;
  logic [15:0] rom_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] acc;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] step_count;

  logic [15:0] mem_op  [65536];
  logic [15:0] mem_arg [65536];

  logic [31:0] dut_outs[$];
  logic [31:0] model_outs[$];

  int n_vec = 0;
  int n_err = 0;

  assign rom_operator = mem_op[rom_addr];
  assign rom_operand  = mem_arg[rom_addr];

  rom_sequencer #(
    .START_ADDR(16'h0000),
    .MAX_STEPS (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_operator(rom_operator),
    .rom_operand (rom_operand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .acc         (acc),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .step_count  (step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge that samples start (edge E).
  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) begin
      mem_op[i]  = 16'h0007;
      mem_arg[i] = 16'h0000;
    end
  endtask

  task automatic load_basic();
    clear_rom();
    mem_op[0] = 16'h0001; mem_arg[0] = 16'd5;
    mem_op[1] = 16'h0002; mem_arg[1] = 16'd3;
    mem_op[2] = 16'h0006; mem_arg[2] = 16'd0;
    mem_op[3] = 16'h0007; mem_arg[3] = 16'd0;
  endtask

  // Runs edges until done/error; captures every accepted result.
  task automatic wait_end(input int bound, input bit rnd_ready, output int cyc, output bit tmo);
    cyc = 0;
    tmo = 1'b1;
    while (cyc < bound) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) dut_outs.push_back(out_data);
      tick();
      cyc++;
      if (done || error) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // Instruction-level interpreter of the program currently in the ROM.
  task automatic model_run(output logic [31:0] m_acc, output logic [15:0] m_pc,
                           output logic [31:0] m_steps, output bit m_done, output bit m_err);
    logic [15:0] op;
    logic [15:0] arg;
    bit fin;
    m_acc = 0; m_pc = 16'h0000; m_steps = 0; m_done = 0; m_err = 0; fin = 0;
    model_outs.delete();
    while (!fin) begin
      if (m_steps == MAXS) begin
        m_err = 1; fin = 1;
      end else begin
        m_steps = m_steps + 1;
        op  = mem_op[m_pc];
        arg = mem_arg[m_pc];
        case (op)
          16'd0: m_pc = m_pc + 1;
          16'd1: begin m_acc = {16'h0, arg}; m_pc = m_pc + 1; end
          16'd2: begin m_acc = m_acc + {16'h0, arg}; m_pc = m_pc + 1; end
          16'd3: begin m_acc = m_acc - {16'h0, arg}; m_pc = m_pc + 1; end
          16'd4: m_pc = arg;
          16'd5: m_pc = (m_acc == 0) ? arg : m_pc + 1;
          16'd6: begin model_outs.push_back(m_acc); m_pc = m_pc + 1; end
          16'd7: begin m_done = 1; fin = 1; end
          default: begin m_err = 1; fin = 1; end
        endcase
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rom_addr, out_valid, busy, done, error} !== {16'h0000, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_ctrl: got addr=%h v/b/d/e=%b%b%b%b expected addr=0000 v/b/d/e=0000",
               rom_addr, out_valid, busy, done, error);
    end
    n_vec++;
    if ({acc, out_data, step_count} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_data: got acc=%h out=%h steps=%h expected all 0", acc, out_data, step_count);
    end
    #2 reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    load_basic();
    out_ready = 1'b1;
    do_start();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
    repeat (3) tick();
    start = 1'b1;  // ignored while busy
    tick();
    start = 1'b0;
    n_vec++;
    if (acc !== 32'd8) begin n_err++; $display("FAIL basic_acc_e4: got %h expected 8", acc); end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_e5: got %b expected 0", out_valid); end
    tick();
    n_vec++;
    if ({out_valid, out_data} !== {1'b1, 32'd8}) begin
      n_err++; $display("FAIL basic_out_e6: got v=%b d=%h expected v=1 d=8", out_valid, out_data);
    end
    tick();
    n_vec++;
    if ({out_valid, rom_addr} !== {1'b0, 16'd3}) begin
      n_err++; $display("FAIL basic_xfer_e7: got v=%b addr=%h expected v=0 addr=3", out_valid, rom_addr);
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_e8: got %b expected 0", done); end
    tick();
    n_vec++;
    if ({done, error, busy, step_count, acc, rom_addr} !== {3'b100, 32'd4, 32'd8, 16'd3}) begin
      n_err++;
      $display("FAIL basic_end_e9: got d/e/b=%b%b%b steps=%0d acc=%h addr=%h expected 100 4 8 3",
               done, error, busy, step_count, acc, rom_addr);
    end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    load_basic();
    out_ready = 1'b0;
    do_start();
    repeat (6) tick();
    n_vec++;
    if ({out_valid, out_data} !== {1'b1, 32'd8}) begin
      n_err++; $display("FAIL bp_out_e6: got v=%b d=%h expected v=1 d=8", out_valid, out_data);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if ({out_valid, out_data, rom_addr} !== {1'b1, 32'd8, 16'd2}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h addr=%h expected v=1 d=8 addr=2",
                 k, out_valid, out_data, rom_addr);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_xfer_e12: got %b expected 0", out_valid); end
    tick();
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL bp_done_e13: got %b expected 0", done); end
    tick();
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL bp_done_e14: got %b expected 1", done); end
    $display("test_backpressure done");
  endtask

  task automatic test_loop();
    int cyc;
    bit tmo;
    clear_rom();
    mem_op[0] = 16'h0001; mem_arg[0] = 16'd3;
    mem_op[1] = 16'h0003; mem_arg[1] = 16'd1;
    mem_op[2] = 16'h0005; mem_arg[2] = 16'd4;
    mem_op[3] = 16'h0004; mem_arg[3] = 16'd1;
    mem_op[4] = 16'h0007; mem_arg[4] = 16'd0;
    out_ready = 1'b1;
    dut_outs.delete();
    do_start();
    wait_end(200, 1'b0, cyc, tmo);
    n_vec++;
    if (tmo) begin n_err++; $display("FAIL loop_timeout: got no finish expected done"); end
    n_vec++;
    if ({done, error, acc, step_count, rom_addr} !== {2'b10, 32'd0, 32'd10, 16'd4}) begin
      n_err++;
      $display("FAIL loop_end: got d/e=%b%b acc=%h steps=%0d addr=%h expected 10 0 10 4",
               done, error, acc, step_count, rom_addr);
    end
    n_vec++;
    if (cyc !== 20) begin n_err++; $display("FAIL loop_cycles: got %0d expected 20", cyc); end
    n_vec++;
    if (dut_outs.size() !== 0) begin n_err++; $display("FAIL loop_nout: got %0d expected 0", dut_outs.size()); end
    $display("test_loop done");
  endtask

  task automatic test_illegal();
    int cyc;
    bit tmo;
    clear_rom();
    mem_op[0] = 16'h0001; mem_arg[0] = 16'd7;
    mem_op[1] = 16'h00FF; mem_arg[1] = 16'd9;
    do_start();
    wait_end(100, 1'b0, cyc, tmo);
    n_vec++;
    if ({tmo, error, done, busy, acc, rom_addr, step_count} !== {4'b0100, 32'd7, 16'd1, 32'd2}) begin
      n_err++;
      $display("FAIL illegal_end: got t/e/d/b=%b%b%b%b acc=%h addr=%h steps=%0d expected 0100 7 1 2",
               tmo, error, done, busy, acc, rom_addr, step_count);
    end
    mem_op[1] = 16'h0007;
    do_start();
    n_vec++;
    if ({error, busy} !== 2'b01) begin
      n_err++; $display("FAIL illegal_clear: got e/b=%b%b expected 01", error, busy);
    end
    wait_end(100, 1'b0, cyc, tmo);
    n_vec++;
    if ({tmo, done, error, acc} !== {3'b010, 32'd7}) begin
      n_err++;
      $display("FAIL illegal_rerun: got t/d/e=%b%b%b acc=%h expected 010 7", tmo, done, error, acc);
    end
    $display("test_illegal done");
  endtask

  task automatic test_watchdog();
    int cyc;
    bit tmo;
    clear_rom();
    mem_op[0] = 16'h0004; mem_arg[0] = 16'd0;
    do_start();
    repeat (33) tick();
    n_vec++;
    if (error !== 1'b0) begin n_err++; $display("FAIL wd_e33: got %b expected 0", error); end
    tick();
    n_vec++;
    if ({error, done, busy, step_count, rom_addr} !== {3'b100, 32'd16, 16'd0}) begin
      n_err++;
      $display("FAIL wd_e34: got e/d/b=%b%b%b steps=%0d addr=%h expected 100 16 0",
               error, done, busy, step_count, rom_addr);
    end
    clear_rom();
    mem_op[0] = 16'h0003; mem_arg[0] = 16'd1;
    do_start();
    wait_end(100, 1'b0, cyc, tmo);
    n_vec++;
    if ({tmo, done, acc} !== {2'b01, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL sub_wrap: got t/d=%b%b acc=%h expected 01 ffffffff", tmo, done, acc);
    end
    $display("test_watchdog done");
  endtask

  task automatic test_pc_wrap();
    int cyc;
    bit tmo;
    clear_rom();
    mem_op[0]     = 16'h0005; mem_arg[0]     = 16'hFFFF;
    mem_op[16'hFFFF] = 16'h0002; mem_arg[16'hFFFF] = 16'd1;
    mem_op[1]     = 16'h0007;
    do_start();
    repeat (2) tick();
    n_vec++;
    if (rom_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_jump: got %h expected ffff", rom_addr); end
    repeat (2) tick();
    n_vec++;
    if ({rom_addr, acc} !== {16'h0000, 32'd1}) begin
      n_err++; $display("FAIL wrap_pc: got addr=%h acc=%h expected 0000 1", rom_addr, acc);
    end
    wait_end(100, 1'b0, cyc, tmo);
    n_vec++;
    if ({tmo, done, rom_addr, step_count} !== {2'b01, 16'd1, 32'd4}) begin
      n_err++;
      $display("FAIL wrap_end: got t/d=%b%b addr=%h steps=%0d expected 01 1 4", tmo, done, rom_addr, step_count);
    end
    $display("test_pc_wrap done");
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit tmo;
    load_basic();
    out_ready = 1'b0;
    do_start();
    repeat (6) tick();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_valid: got %b expected 1", out_valid); end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, busy, done, error, rom_addr, acc, out_data, step_count} !== {4'b0000, 16'h0, 96'd0}) begin
      n_err++;
      $display("FAIL rmid_async: got v/b/d/e=%b%b%b%b addr=%h acc=%h out=%h steps=%0d expected all 0",
               out_valid, busy, done, error, rom_addr, acc, out_data, step_count);
    end
    #2 reset = 1'b1;
    out_ready = 1'b1;
    dut_outs.delete();
    do_start();
    wait_end(100, 1'b0, cyc, tmo);
    n_vec++;
    if ({tmo, done, acc, cyc} !== {2'b01, 32'd8, 32'd9}) begin
      n_err++; $display("FAIL rmid_rerun: got t/d=%b%b acc=%h cyc=%0d expected 01 8 9", tmo, done, acc, cyc);
    end
    n_vec++;
    if (dut_outs.size() !== 1 || dut_outs[0] !== 32'd8) begin
      n_err++; $display("FAIL rmid_out: got n=%0d expected one result of 8", dut_outs.size());
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [31:0] m_acc;
    logic [15:0] m_pc;
    logic [31:0] m_steps;
    bit m_done, m_err, tmo;
    int cyc, r;
    for (int it = 0; it < 12; it++) begin
      clear_rom();
      for (int a = 0; a < 12; a++) begin
        r = $urandom_range(0, 99);
        mem_arg[a] = 16'($urandom);
        if      (r < 10) mem_op[a] = 16'd0;
        else if (r < 30) mem_op[a] = 16'd1;
        else if (r < 45) mem_op[a] = 16'd2;
        else if (r < 60) mem_op[a] = 16'd3;
        else if (r < 68) begin mem_op[a] = 16'd4; mem_arg[a] = 16'($urandom_range(0, 13)); end
        else if (r < 78) begin mem_op[a] = 16'd5; mem_arg[a] = 16'($urandom_range(0, 13)); end
        else if (r < 92) mem_op[a] = 16'd6;
        else if (r < 96) mem_op[a] = 16'd7;
        else             mem_op[a] = 16'($urandom_range(8, 1000));
      end
      model_run(m_acc, m_pc, m_steps, m_done, m_err);
      dut_outs.delete();
      do_start();
      wait_end(600, 1'b1, cyc, tmo);
      out_ready = 1'b1;
      n_vec++;
      if ({tmo, done, error, acc, rom_addr, step_count} !== {1'b0, m_done, m_err, m_acc, m_pc, m_steps}) begin
        n_err++;
        $display("FAIL rand%0d_state: got t/d/e=%b%b%b acc=%h addr=%h steps=%0d expected 0%b%b %h %h %0d",
                 it, tmo, done, error, acc, rom_addr, step_count, m_done, m_err, m_acc, m_pc, m_steps);
      end
      n_vec++;
      if (dut_outs.size() !== model_outs.size()) begin
        n_err++;
        $display("FAIL rand%0d_nout: got %0d expected %0d", it, dut_outs.size(), model_outs.size());
      end else begin
        foreach (model_outs[k]) begin
          n_vec++;
          if (dut_outs[k] !== model_outs[k]) begin
            n_err++;
            $display("FAIL rand%0d_out%0d: got %h expected %h", it, k, dut_outs[k], model_outs[k]);
          end
        end
      end
      $display("rand program %0d: steps=%0d outs=%0d done=%b error=%b", it, m_steps, model_outs.size(), m_done, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_loop();
    test_illegal();
    test_watchdog();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
